cnn_job_feeder: RTL and testbench
=================================

Name: cnn_job_feeder

Overview:
Initiator side of the CNN engine's start/X/Y/Z/done interface.
- A host pushes operand triples {X,Y,Z} into an internal FIFO.
- The feeder launches one engine job per triple: it presents the operands, pulses start, and holds the operands stable until the engine signals done.
- It counts completed jobs and flags engines that never finish.
- It sits between the host/stream source and the engine top in the CNN datapath.

Parameters:
- W, 8, operand width of X/Y/Z.
- DEPTH, 8, FIFO entries; power of two, at least 2.
- TIMEOUT, 1023, maximum WAIT cycles before a job is abandoned.
- CNT_W, 16, width of the completed-job counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous clear of FIFO, FSM and error flag.
- in_valid  in  1  host triple valid.
- in_ready  out  1  FIFO can accept a triple; equals !full.
- in_x, in_y, in_z  in  W each  host operands.
- eng_start  out  1  one-cycle job launch pulse to the engine.
- eng_x, eng_y, eng_z  out  W each  operands, held stable for the whole job.
- eng_done  in  1  engine completion (level or pulse).
- busy  out  1  high in any state other than IDLE.
- jobs_done  out  CNT_W  count of completed jobs; wraps modulo 2^CNT_W.
- timeout_err  out  1  sticky flag: a job exceeded TIMEOUT.

Behaviour:
- Reset (async, rst=1):
  - FIFO empty; state IDLE.
  - eng_start=0, eng_x/y/z=0, busy=0, jobs_done=0, timeout_err=0.
  - in_ready=1 once reset has applied.
- FIFO:
  - Push on in_valid & in_ready.
  - Pop only in LOAD.
  - Push and pop in the same cycle are both performed; occupancy is unchanged.
  - in_valid while full is ignored: nothing is stored and no error is raised.
  - Read/write pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - Occupancy is tracked with a (log2(DEPTH)+1)-bit count.
- FSM states: IDLE, LOAD, START, WAIT, DONE.
  - IDLE: if the FIFO is non-empty, go to LOAD.
  - LOAD: pop the head triple into the eng_x/y/z hold registers; go to START.
  - START: eng_start=1 for exactly this cycle; clear the arm flag and the timeout counter; go to WAIT.
  - WAIT:
    - eng_done is ignored until it has been sampled low at least once after START (arm flag set). This rejects a stale done held high from the previous job.
    - Armed and eng_done=1: go to DONE.
    - Otherwise the timeout counter increments each cycle.
    - Timeout counter reaching TIMEOUT: set timeout_err, go to IDLE. jobs_done is not incremented; the operand is dropped.
  - DONE: jobs_done += 1; go to IDLE.
- Outputs between jobs: eng_x/y/z change only in LOAD and keep their last value in all other states.
- Latency:
  - A triple pushed at edge t into an empty FIFO with the FSM in IDLE gives LOAD at t+1, eng_start high in the cycle after edge t+2.
  - Best-case job period is 5 cycles plus the engine's run time.
  - Back-to-back jobs never overlap: the next eng_start comes at least 3 cycles after DONE is entered.
- flush (synchronous, priority over all other activity):
  - Empties the FIFO; a same-cycle push is discarded.
  - Returns the FSM to IDLE and clears timeout_err.
  - Keeps jobs_done.
  - Has no effect on eng_x/y/z.
  - A job in flight is abandoned and does not count.
- rst mid-job: takes effect immediately, including clearing eng_start.

Decomposition:
- Shared package `cnn_pkg` holds:
  - The FSM state encoding (S_IDLE..S_DONE, 3 bits).
  - Default constants for W, DEPTH, TIMEOUT and CNT_W.
- One sub-module, `sync_fifo` (params W3 = 3*W and DEPTH), with ports:
  - Inputs: clk, rst, clr, push, din, pop.
  - Outputs: dout, full, empty.
- FSM, arm flag, timeout counter and job counter live in cnn_job_feeder.

Test Plan:
1. Push one triple (0x11,0x22,0x33); engine model asserts done 10 cycles after start -> one eng_start pulse; eng_x/y/z = 11/22/33 stable through WAIT; jobs_done=1; busy falls after DONE.
2. Push 9 triples back-to-back with DEPTH=8 while the engine stalls -> in_ready deasserts after 8 stored (plus 1 popped into LOAD); all accepted triples later launch in push order; no corruption on pointer wrap.
3. Engine holds done high from the previous job and lowers it 2 cycles after the new start, then raises it 5 cycles later -> no early completion; jobs_done increments once, on the second rise.
4. Engine never asserts done, TIMEOUT=20 -> timeout_err=1 after 20 WAIT cycles; jobs_done unchanged; the next queued job launches; flush clears timeout_err.
5. Assert flush during WAIT with 3 entries queued -> FSM returns to IDLE; FIFO empty; in_ready=1; no further eng_start; jobs_done retained.
6. Assert rst asynchronously mid-START -> eng_start drops in the same cycle; all outputs at reset values; FIFO empty.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN job feeder: FSM state encoding and default sizing.
package cnn_pkg;

  localparam int unsigned CNN_W       = 8;
  localparam int unsigned CNN_DEPTH   = 8;
  localparam int unsigned CNN_TIMEOUT = 1023;
  localparam int unsigned CNN_CNT_W   = 16;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_START = 3'd2,
    S_WAIT  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a combinational head read and a synchronous clear that beats push/pop.
module sync_fifo
  import cnn_pkg::*;
#(
  parameter int unsigned W3    = 3 * CNN_W,
  parameter int unsigned DEPTH = CNN_DEPTH
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          push,
  input  logic [W3-1:0] din,
  input  logic          pop,
  output logic [W3-1:0] dout,
  output logic          full,
  output logic          empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [W3-1:0] mem [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   cnt_q;
  logic          do_push, do_pop;

  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rptr_q];

  always_ff @(posedge clk) begin
    if (do_push && !clr) begin
      mem[wptr_q] <= din;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else if (clr) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + AW'(1);
      if (do_pop)  rptr_q <= rptr_q + AW'(1);
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/cnn_job_feeder.sv
// Queues host operand triples and launches them one at a time on the CNN engine's
// start/X/Y/Z/done handshake, counting completions and flagging engines that hang.
module cnn_job_feeder
  import cnn_pkg::*;
#(
  parameter int unsigned W       = CNN_W,
  parameter int unsigned DEPTH   = CNN_DEPTH,
  parameter int unsigned TIMEOUT = CNN_TIMEOUT,
  parameter int unsigned CNT_W   = CNN_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_x,
  input  logic [W-1:0]     in_y,
  input  logic [W-1:0]     in_z,
  output logic             eng_start,
  output logic [W-1:0]     eng_x,
  output logic [W-1:0]     eng_y,
  output logic [W-1:0]     eng_z,
  input  logic             eng_done,
  output logic             busy,
  output logic [CNT_W-1:0] jobs_done,
  output logic             timeout_err
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  state_t           state_q, state_d;
  logic [3*W-1:0]   head;
  logic             fifo_full, fifo_empty;
  logic             arm_q;
  logic [TW-1:0]    tcnt_q;
  logic             job_ok, tmo_hit;
  logic [W-1:0]     x_q, y_q, z_q;
  logic [CNT_W-1:0] jobs_q;
  logic             err_q;

  assign in_ready = ~fifo_full;

  sync_fifo #(
    .W3    (3 * W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (flush),
    .push  (in_valid & ~fifo_full),
    .din   ({in_x, in_y, in_z}),
    .pop   (state_q == S_LOAD),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // done only counts once it has been seen low after START, so a level held over
  // from the previous job cannot complete this one.
  assign job_ok  = arm_q & eng_done;
  assign tmo_hit = (tcnt_q == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE:  if (!fifo_empty) state_d = S_LOAD;
        S_LOAD:  state_d = S_START;
        S_START: state_d = S_WAIT;
        S_WAIT: begin
          if (job_ok)       state_d = S_DONE;
          else if (tmo_hit) state_d = S_IDLE;
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    eng_start = (state_q == S_START);
    busy      = (state_q != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      arm_q  <= 1'b0;
      tcnt_q <= '0;
      x_q    <= '0;
      y_q    <= '0;
      z_q    <= '0;
      jobs_q <= '0;
      err_q  <= 1'b0;
    end else if (flush) begin
      err_q <= 1'b0;
    end else begin
      if (state_q == S_LOAD) begin
        {x_q, y_q, z_q} <= head;
      end
      if (state_q == S_START) begin
        arm_q  <= 1'b0;
        tcnt_q <= '0;
      end
      if (state_q == S_WAIT) begin
        if (!eng_done) arm_q <= 1'b1;
        if (!job_ok) begin
          tcnt_q <= tcnt_q + TW'(1);
          if (tmo_hit) err_q <= 1'b1;
        end
      end
      if (state_q == S_DONE) begin
        jobs_q <= jobs_q + CNT_W'(1);
      end
    end
  end

  assign eng_x       = x_q;
  assign eng_y       = y_q;
  assign eng_z       = z_q;
  assign jobs_done   = jobs_q;
  assign timeout_err = err_q;

endmodule

// File: tb/tb_cnn_job_feeder.sv
// Directed plus randomized bench for cnn_job_feeder with a cycle-level engine and job model.
module tb_cnn_job_feeder;

  localparam int unsigned W     = 8;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned TO    = 20;
  localparam int unsigned CW    = 16;

  logic          clk = 1'b0;
  logic          rst, flush, in_valid, in_ready;
  logic [W-1:0]  in_x, in_y, in_z;
  logic          eng_start, eng_done, busy, timeout_err;
  logic [W-1:0]  eng_x, eng_y, eng_z;
  logic [CW-1:0] jobs_done;

  always #5 clk = ~clk;

  cnn_job_feeder #(
    .W       (W),
    .DEPTH   (DEPTH),
    .TIMEOUT (TO),
    .CNT_W   (CW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_x        (in_x),
    .in_y        (in_y),
    .in_z        (in_z),
    .eng_start   (eng_start),
    .eng_x       (eng_x),
    .eng_y       (eng_y),
    .eng_z       (eng_z),
    .eng_done    (eng_done),
    .busy        (busy),
    .jobs_done   (jobs_done),
    .timeout_err (timeout_err)
  );

  int n_chk = 0;
  int n_fail = 0;

  // Model: queued jobs with their engine behaviour (stale-high cycles s, rise cycle l, 0 = never).
  logic [3*W-1:0] exp_q[$];
  int             s_q[$];
  int             l_q[$];
  int             occ, m_jobs, since, res_k, cur_s, cur_l, in_s, in_l;
  bit             m_err, in_flight, res_to, last_acc;
  logic [3*W-1:0] cur_ops;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Engine done level in WAIT cycle k (k=1 is the cycle after the start pulse).
  function automatic bit done_at(input int s, input int l, input int k);
    return (k <= s) || (l != 0 && k >= l);
  endfunction

  // A job completes in the first cycle done is high after having been seen low;
  // otherwise it is abandoned after TO cycles of waiting.
  task automatic predict(input int s, input int l, output int k, output bit to);
    bit armed, hit, d;
    armed = 0; hit = 0; k = TO; to = 1;
    for (int i = 1; i <= int'(TO); i++) begin
      d = done_at(s, l, i);
      if (!hit) begin
        if (armed && d) begin
          hit = 1; k = i; to = 0;
        end else if (!d) begin
          armed = 1;
        end
      end
    end
  endtask

  task automatic set_in(input logic [7:0] x, input logic [7:0] y, input logic [7:0] z,
                        input int s, input int l);
    in_x = x; in_y = y; in_z = z; in_s = s; in_l = l;
  endtask

  task automatic tick();
    bit acc, fl;
    logic [3*W-1:0] din;
    acc = in_valid && in_ready && !flush;
    fl  = flush;
    din = {in_x, in_y, in_z};
    @(posedge clk);
    #1;
    last_acc = acc;
    if (fl) begin
      occ = 0; exp_q.delete(); s_q.delete(); l_q.delete(); in_flight = 0; m_err = 0;
    end else if (acc) begin
      occ++; exp_q.push_back(din); s_q.push_back(in_s); l_q.push_back(in_l);
    end
    if (in_flight) begin
      since++;
      if (!res_to && since == res_k + 2) begin
        m_jobs++;
        chk("jobs_done", jobs_done, CW'(m_jobs));
        chk("busy_after_done", busy, 0);
        in_flight = 0;
      end else if (res_to && since == res_k + 1) begin
        m_err = 1;
        chk("timeout_err_set", timeout_err, 1);
        chk("jobs_after_timeout", jobs_done, CW'(m_jobs));
        chk("busy_after_timeout", busy, 0);
        in_flight = 0;
      end else begin
        chk("ops_stable", {eng_x, eng_y, eng_z}, cur_ops);
      end
    end
    if (eng_start) begin
      chk("start_no_overlap", in_flight, 0);
      chk("start_has_job", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        cur_ops = exp_q.pop_front(); cur_s = s_q.pop_front(); cur_l = l_q.pop_front();
        chk("start_ops", {eng_x, eng_y, eng_z}, cur_ops);
        occ--; in_flight = 1; since = 0;
        predict(cur_s, cur_l, res_k, res_to);
      end
    end
    chk("in_ready", in_ready, occ < int'(DEPTH));
    chk("timeout_err_level", timeout_err, m_err);
    if (in_flight && since >= 1) eng_done = done_at(cur_s, cur_l, since);
  endtask

  task automatic drain(input int bound);
    int n;
    n = 0;
    while ((in_flight || exp_q.size() != 0) && n < bound) begin
      tick();
      n++;
    end
    chk("drain_bound", n < bound, 1);
    repeat (4) tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, l, r, n;
    rst = 0; flush = 0; in_valid = 0; eng_done = 0;
    set_in(0, 0, 0, 0, 0);
    occ = 0; m_jobs = 0; m_err = 0; in_flight = 0; last_acc = 0;
    since = 0; res_k = 0; res_to = 0; cur_ops = '0; cur_s = 0; cur_l = 0;

    #1 rst = 1;
    #1;
    chk("rst_start", eng_start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ops", {eng_x, eng_y, eng_z}, 0);
    chk("rst_jobs", jobs_done, 0);
    chk("rst_err", timeout_err, 0);
    chk("rst_ready", in_ready, 1);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 0;

    // Single job, done rises 10 cycles after start; check launch latency.
    set_in(8'h11, 8'h22, 8'h33, 0, 10);
    in_valid = 1; tick(); in_valid = 0;
    tick(); chk("latency_load", eng_start, 0);
    tick(); chk("latency_start", eng_start, 1);
    chk("t1_ops", {eng_x, eng_y, eng_z}, 24'h112233);
    drain(200);
    chk("t1_jobs", jobs_done, 1);
    chk("t1_busy", busy, 0);

    // Ten back-to-back pushes against a slow engine: nine fit, the tenth is refused.
    for (int i = 0; i < 10; i++) begin
      set_in(8'(8'hA0 + i), 8'(i), 8'(8'hF0 - i), 0, 15);
      in_valid = 1;
      tick();
    end
    in_valid = 0;
    chk("t2_full", in_ready, 0);
    drain(2000);
    chk("t2_jobs", jobs_done, 10);

    // Done still high from the previous job, drops at cycle 2, rises at cycle 7.
    chk("t3_stale_high", eng_done, 1);
    set_in(8'h5A, 8'hC3, 8'h3C, 1, 7);
    in_valid = 1; tick(); in_valid = 0;
    drain(200);
    chk("t3_jobs", jobs_done, 11);

    // Hung engine times out, the queued job still runs, flush clears the error.
    set_in(8'h01, 8'h02, 8'h03, 0, 0);
    in_valid = 1; tick();
    set_in(8'h04, 8'h05, 8'h06, 0, 4);
    tick(); in_valid = 0;
    drain(500);
    chk("t4_err", timeout_err, 1);
    chk("t4_jobs", jobs_done, 12);
    flush = 1; tick(); flush = 0;
    chk("t4_flush_clr", timeout_err, 0);

    // Flush while waiting with three entries queued; a same-cycle push is discarded.
    for (int i = 0; i < 4; i++) begin
      set_in(8'(8'h40 + i), 8'(8'h50 + i), 8'(8'h60 + i), 0, 0);
      in_valid = 1;
      tick();
    end
    in_valid = 0;
    repeat (3) tick();
    chk("t5_busy_wait", busy, 1);
    set_in(8'h77, 8'h77, 8'h77, 0, 3);
    in_valid = 1; flush = 1; tick(); flush = 0; in_valid = 0;
    chk("t5_idle", busy, 0);
    chk("t5_ready", in_ready, 1);
    chk("t5_jobs", jobs_done, 12);
    chk("t5_ops_kept", {eng_x, eng_y, eng_z}, 24'h405060);
    repeat (30) tick();
    chk("t5_quiet", busy, 0);

    // Randomized jobs with random gaps and engine behaviour, including hangs.
    for (int j = 0; j < 40; j++) begin
      r = $urandom_range(0, 9);
      s = $urandom_range(0, 2);
      l = (r == 0) ? 0 : (r == 1) ? 25 : $urandom_range(2, 18);
      set_in(8'($urandom), 8'($urandom), 8'($urandom), s, l);
      in_valid = 1;
      n = 0;
      tick();
      while (!last_acc && n < 500) begin
        tick();
        n++;
      end
      in_valid = 0;
      chk("rnd_accept", last_acc, 1);
      repeat ($urandom_range(0, 3)) tick();
    end
    drain(5000);
    chk("rnd_jobs", jobs_done, CW'(m_jobs));

    // Asynchronous reset in the middle of the start pulse.
    set_in(8'h99, 8'h88, 8'h77, 0, 3);
    in_valid = 1; tick(); in_valid = 0;
    n = 0;
    while (!eng_start && n < 10) begin
      tick();
      n++;
    end
    chk("t6_start_seen", eng_start, 1);
    #2 rst = 1;
    #1;
    chk("t6_start_drop", eng_start, 0);
    chk("t6_busy", busy, 0);
    chk("t6_ops", {eng_x, eng_y, eng_z}, 0);
    chk("t6_jobs", jobs_done, 0);
    chk("t6_err", timeout_err, 0);
    chk("t6_ready", in_ready, 1);
    occ = 0; exp_q.delete(); s_q.delete(); l_q.delete();
    in_flight = 0; m_jobs = 0; m_err = 0; eng_done = 0;
    @(posedge clk);
    #1 rst = 0;
    set_in(8'h12, 8'h34, 8'h56, 0, 5);
    in_valid = 1; tick(); in_valid = 0;
    drain(200);
    chk("t6_recover", jobs_done, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
